// File: rtl/jtag_l2_burst_ctrl_if.sv
// Signal bundle for jtag_l2_burst_ctrl: command, write-beat stream, read-beat stream,
// L2 memory port and status. The slave modport is the controller side.
interface jtag_l2_burst_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 8
) ();
    localparam int unsigned BYTES = DATA_WIDTH / 8;

    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_we_i;
    logic [ADDR_WIDTH-1:0] cmd_addr_i;
    logic [LEN_WIDTH-1:0]  cmd_len_i;
    logic                  wdata_valid_i;
    logic                  wdata_ready_o;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic                  rdata_valid_o;
    logic                  rdata_ready_i;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [BYTES-1:0]      mem_be_o;
    logic                  mem_gnt_i;
    logic                  mem_rvalid_i;
    logic                  mem_err_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  err_o;

    modport slave (
        input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_len_i,
        input  wdata_valid_i, wdata_i, rdata_ready_i,
        input  mem_gnt_i, mem_rvalid_i, mem_err_i, mem_rdata_i,
        output cmd_ready_o, wdata_ready_o, rdata_valid_o, rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        output busy_o, done_o, err_o
    );

    modport master (
        output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_len_i,
        output wdata_valid_i, wdata_i, rdata_ready_i,
        output mem_gnt_i, mem_rvalid_i, mem_err_i, mem_rdata_i,
        input  cmd_ready_o, wdata_ready_o, rdata_valid_o, rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o,
        input  busy_o, done_o, err_o
    );
endinterface

// File: rtl/jtag_l2_burst_ctrl.sv
// Multi-beat burst engine from the JTAG debug data path to the L2 req/gnt/rvalid port,
// one outstanding beat at a time, with a buffered read-response FIFO.
module jtag_l2_burst_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned RSP_DEPTH  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    jtag_l2_burst_ctrl_if.slave  bus
);
    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned PW    = $clog2(RSP_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(BYTES);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] REQ      = 2'd1;
    localparam logic [1:0] WAIT_RSP = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
    logic [PW:0]           wptr_q, rptr_q;
    logic                  fifo_empty, fifo_full;
    logic                  push, pop, req, accept, rsp;

    // Extra pointer MSB tells full from empty when the index bits match.
    assign fifo_empty = wptr_q == rptr_q;
    assign fifo_full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);

    assign accept = (state_q == IDLE) && bus.cmd_valid_i;
    assign req    = (state_q == REQ) && (we_q ? bus.wdata_valid_i : !fifo_full);
    assign rsp    = (state_q == WAIT_RSP) && bus.mem_rvalid_i;
    assign push   = rsp && !we_q;
    assign pop    = !fifo_empty && bus.rdata_ready_i;

    assign bus.cmd_ready_o   = state_q == IDLE;
    assign bus.mem_req_o     = req;
    assign bus.mem_we_o      = we_q;
    assign bus.mem_addr_o    = addr_q;
    assign bus.mem_wdata_o   = bus.wdata_i;
    assign bus.mem_be_o      = '1;
    assign bus.wdata_ready_o = (state_q == REQ) && we_q && bus.mem_gnt_i;
    assign bus.rdata_valid_o = !fifo_empty;
    assign bus.rdata_o       = fifo_q[rptr_q[PW-1:0]];
    assign bus.busy_o        = state_q != IDLE;
    assign bus.done_o        = done_q;
    assign bus.err_o         = err_q;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = bus.cmd_we_i;
                    addr_d  = bus.cmd_addr_i & ALIGN_MASK;
                    len_d   = bus.cmd_len_i;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (req && bus.mem_gnt_i) state_d = WAIT_RSP;
            end
            WAIT_RSP: begin
                // Errors are recorded but never cut the burst short.
                if (rsp) begin
                    if (bus.mem_err_i) err_d = 1'b1;
                    if (cnt_q == len_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + LEN_WIDTH'(1);
                        addr_d  = addr_q + ADDR_STEP;
                        state_d = REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (push) wptr_q <= wptr_q + (PW + 1)'(1);
            if (pop)  rptr_q <= rptr_q + (PW + 1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wptr_q[PW-1:0]] <= bus.mem_rdata_i;
    end
endmodule

// File: tb/tb_jtag_l2_burst_ctrl.sv
// Self-checking bench for jtag_l2_burst_ctrl: table of bursts plus hand-written corner
// sequences, with an L2 responder and queue-based scoreboards for addresses and data.
module tb_jtag_l2_burst_ctrl;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    jtag_l2_burst_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    jtag_l2_burst_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .RSP_DEPTH(4)
    ) dut (
        .clk_i (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [31:0] d0;
        logic [31:0] err_addr;
        logic        exp_err;
    } vec_t;

    vec_t vecs [5];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [31:0] exp_addr [$];
    logic        exp_we   [$];
    logic [31:0] exp_wd   [$];
    logic [31:0] exp_rd   [$];
    logic [31:0] wq       [$];
    logic [31:0] mem      [logic [31:0]];
    logic [31:0] shadow   [logic [31:0]];

    logic        rsp_pend = 1'b0;
    logic        rsp_err  = 1'b0;
    logic        pop_pend = 1'b0;
    logic [31:0] rsp_data = '0;
    logic [31:0] err_addr = 32'h1;
    int unsigned grant_cnt  = 0;
    int unsigned stall_at   = 0;
    int unsigned stall_left = 0;
    int unsigned done_cnt   = 0;
    int unsigned cons_cnt   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, bus.cmd_ready_o, 1);
        chk({tag, "_mem_req"}, bus.mem_req_o, 0);
        chk({tag, "_mem_we"}, bus.mem_we_o, 0);
        chk({tag, "_mem_addr"}, bus.mem_addr_o, 0);
        chk({tag, "_wdata_ready"}, bus.wdata_ready_o, 0);
        chk({tag, "_rdata_valid"}, bus.rdata_valid_o, 0);
        chk({tag, "_busy"}, bus.busy_o, 0);
        chk({tag, "_done"}, bus.done_o, 0);
        chk({tag, "_err"}, bus.err_o, 0);
    endtask

    // Called at posedge+1 with the controller idle; returns one cycle after the accept edge.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [7:0] len,
                         input logic [31:0] d0);
        logic [31:0] a;
        for (int unsigned i = 0; i <= len; i++) begin
            a = (addr & 32'hFFFF_FFFC) + 32'(i * 4);
            exp_addr.push_back(a);
            exp_we.push_back(we);
            if (we) begin
                wq.push_back(d0 + 32'(i));
                exp_wd.push_back(d0 + 32'(i));
                shadow[a] = d0 + 32'(i);
            end else begin
                exp_rd.push_back(shadow.exists(a) ? shadow[a] : dflt(a));
            end
        end
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = we;
        bus.cmd_addr_i  = addr;
        bus.cmd_len_i   = len;
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0;
        chk("cmd_accept_busy", bus.busy_o, 1);
    endtask

    task automatic wait_done(input int unsigned maxc, output int unsigned cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        while (cyc < maxc && !ok) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.done_o) ok = 1'b1;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: no done_o within %0d cycles, expected a pulse", maxc);
        end
    endtask

    // L2 responder and stream monitors; all decisions made on the falling edge.
    initial begin
        logic [31:0] a;
        bus.mem_gnt_i     = 1'b0;
        bus.mem_rvalid_i  = 1'b0;
        bus.mem_err_i     = 1'b0;
        bus.mem_rdata_i   = '0;
        bus.wdata_valid_i = 1'b0;
        bus.wdata_i       = '0;
        forever begin
            @(negedge clk);
            if (pop_pend) begin
                void'(wq.pop_front());
                pop_pend = 1'b0;
            end
            bus.wdata_valid_i = wq.size() != 0;
            bus.wdata_i       = (wq.size() != 0) ? wq[0] : '0;
            if (bus.done_o) done_cnt++;
            if (bus.rdata_valid_o && bus.rdata_ready_i) begin
                if (exp_rd.size() == 0) chk("rdata_unexpected", bus.rdata_valid_o, 0);
                else chk("rdata", bus.rdata_o, exp_rd.pop_front());
            end
            bus.mem_rvalid_i = rsp_pend;
            bus.mem_rdata_i  = rsp_data;
            bus.mem_err_i    = rsp_pend && rsp_err;
            rsp_pend = 1'b0;
            if (bus.mem_req_o) begin
                a = bus.mem_addr_o;
                if (exp_addr.size() == 0) begin
                    chk("req_unexpected", bus.mem_req_o, 0);
                    bus.mem_gnt_i = 1'b0;
                end else if (stall_left > 0 && grant_cnt == stall_at) begin
                    bus.mem_gnt_i = 1'b0;
                    stall_left--;
                    chk("stall_addr_stable", a, exp_addr[0]);
                    if (exp_wd.size() != 0) chk("stall_wdata_stable", bus.mem_wdata_o, exp_wd[0]);
                end else begin
                    bus.mem_gnt_i = 1'b1;
                    chk("req_addr", a, exp_addr.pop_front());
                    chk("req_we", bus.mem_we_o, exp_we.pop_front());
                    chk("req_be", bus.mem_be_o, 4'hF);
                    if (bus.mem_we_o) begin
                        if (exp_wd.size() != 0) chk("req_wdata", bus.mem_wdata_o, exp_wd.pop_front());
                        mem[a]   = bus.mem_wdata_o;
                        pop_pend = 1'b1;
                        rsp_data = '0;
                    end else begin
                        rsp_data = mem.exists(a) ? mem[a] : dflt(a);
                    end
                    rsp_err  = a == err_addr;
                    rsp_pend = 1'b1;
                    grant_cnt++;
                end
            end else begin
                bus.mem_gnt_i = 1'b0;
            end
            #1;
            chk("wdata_ready", bus.wdata_ready_o, bus.mem_gnt_i && bus.mem_req_o && bus.mem_we_o);
            if (bus.wdata_ready_o && bus.wdata_valid_i) cons_cnt++;
        end
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned cyc, d0c, c0, g0;
        bit ok;
        vecs[0] = '{we: 1'b1, addr: 32'h100, len: 8'd3, d0: 32'hA0,        err_addr: 32'h1,   exp_err: 1'b0};
        vecs[1] = '{we: 1'b0, addr: 32'h100, len: 8'd3, d0: 32'h0,         err_addr: 32'h1,   exp_err: 1'b0};
        vecs[2] = '{we: 1'b1, addr: 32'h43,  len: 8'd0, d0: 32'hDEAD_0000, err_addr: 32'h40,  exp_err: 1'b1};
        vecs[3] = '{we: 1'b0, addr: 32'h40,  len: 8'd1, d0: 32'h0,         err_addr: 32'h1,   exp_err: 1'b0};
        vecs[4] = '{we: 1'b0, addr: 32'h1F0, len: 8'd0, d0: 32'h0,         err_addr: 32'h1F0, exp_err: 1'b1};

        rst_n             = 1'b0;
        bus.cmd_valid_i   = 1'b0;
        bus.cmd_we_i      = 1'b0;
        bus.cmd_addr_i    = '0;
        bus.cmd_len_i     = '0;
        bus.rdata_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int unsigned v = 0; v < 5; v++) begin
            err_addr = vecs[v].err_addr;
            d0c      = done_cnt;
            issue(vecs[v].we, vecs[v].addr, vecs[v].len, vecs[v].d0);
            wait_done(64, cyc, ok);
            if (ok) begin
                chk("vec_burst_cycles", cyc, 2 * (32'(vecs[v].len) + 1));
                chk("vec_err_at_done", bus.err_o, vecs[v].exp_err);
                chk("vec_ready_at_done", bus.cmd_ready_o, 1);
            end
            repeat (3) @(posedge clk);
            #1;
            chk("vec_done_pulses", done_cnt - d0c, 1);
            chk("vec_err_sticky", bus.err_o, vecs[v].exp_err);
            chk("vec_idle", bus.busy_o, 0);
            chk("vec_addr_left", exp_addr.size(), 0);
            chk("vec_rdata_left", exp_rd.size(), 0);
        end

        // Read backpressure: four beats fill the FIFO, then requests must stop.
        err_addr          = 32'h1;
        bus.rdata_ready_i = 1'b0;
        g0                = grant_cnt;
        issue(1'b0, 32'h100, 8'd7, 32'h0);
        repeat (20) @(posedge clk);
        #1;
        chk("bp_grants_held", grant_cnt - g0, 4);
        chk("bp_req_low", bus.mem_req_o, 0);
        chk("bp_still_busy", bus.busy_o, 1);
        chk("bp_fifo_valid", bus.rdata_valid_o, 1);
        bus.rdata_ready_i = 1'b1;
        wait_done(100, cyc, ok);
        repeat (6) @(posedge clk);
        #1;
        chk("bp_total_grants", grant_cnt - g0, 8);
        chk("bp_all_words", exp_rd.size(), 0);
        chk("bp_drained", bus.rdata_valid_o, 0);

        // Wait states on beat 2 of a write burst.
        c0         = cons_cnt;
        stall_at   = grant_cnt + 1;
        stall_left = 3;
        issue(1'b1, 32'h200, 8'd3, 32'hB0);
        wait_done(100, cyc, ok);
        if (ok) chk("ws_cycles", cyc, 11);
        repeat (3) @(posedge clk);
        #1;
        chk("ws_consumed", cons_cnt - c0, 4);
        chk("ws_stall_used", stall_left, 0);
        chk("ws_stream_empty", wq.size(), 0);
        issue(1'b0, 32'h200, 8'd3, 32'h0);
        wait_done(64, cyc, ok);
        repeat (3) @(posedge clk);
        #1;
        chk("ws_readback_left", exp_rd.size(), 0);

        // Error on the middle beat, address wrap, then a command in the done cycle.
        err_addr = 32'hFFFF_FFFC;
        d0c      = done_cnt;
        issue(1'b0, 32'hFFFF_FFF8, 8'd2, 32'h0);
        wait_done(64, cyc, ok);
        if (ok) begin
            chk("wrap_cycles", cyc, 6);
            chk("wrap_err_at_done", bus.err_o, 1);
            err_addr = 32'h1;
            issue(1'b0, 32'h100, 8'd0, 32'h0);
            chk("b2b_err_cleared", bus.err_o, 0);
            chk("b2b_first_req", bus.mem_req_o, 1);
            chk("b2b_first_addr", bus.mem_addr_o, 32'h100);
            wait_done(16, cyc, ok);
            if (ok) chk("b2b_cycles", cyc, 2);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("wrap_done_pulses", done_cnt - d0c, 2);
        chk("wrap_addr_left", exp_addr.size(), 0);
        chk("wrap_rdata_left", exp_rd.size(), 0);

        // Reset while waiting for the response of beat 2 of 4.
        bus.rdata_ready_i = 1'b0;
        g0                = grant_cnt;
        issue(1'b0, 32'h300, 8'd3, 32'h0);
        cyc = 0;
        while (grant_cnt != g0 + 2 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("rst_at_beat2", grant_cnt - g0, 2);
        chk("rst_busy_before", bus.busy_o, 1);
        chk("rst_fifo_before", bus.rdata_valid_o, 1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        exp_addr.delete();
        exp_we.delete();
        exp_rd.delete();
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_late_rvalid_dropped", bus.rdata_valid_o, 0);
        chk("rst_stays_idle", bus.busy_o, 0);
        bus.rdata_ready_i = 1'b1;
        issue(1'b0, 32'h200, 8'd1, 32'h0);
        wait_done(64, cyc, ok);
        if (ok) chk("rst_recover_cycles", cyc, 4);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_recover_rdata_left", exp_rd.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/jtag_l2_burst_ctrl.md
# jtag_l2_burst_ctrl

Parametrised burst engine between the JTAG debug data path and the L2 memory port, in the `clk_i` domain. It accepts a single command (direction, start address, beat count) plus a write-data stream, then issues word accesses on a req/gnt/rvalid memory port with address auto-increment. Read data returns through a buffered response FIFO with backpressure. It replaces single-word write32/read32 access with configurable-width, multi-beat bursts and error reporting.

## Interface
- ADDR_WIDTH, 32, memory byte-address width
- DATA_WIDTH, 32, beat width; power of two, ≥8; BYTES = DATA_WIDTH/8
- LEN_WIDTH, 8, width of beat-count field; max burst 2^LEN_WIDTH beats
- RSP_DEPTH, 4, read-response FIFO entries; power of two, ≥2
- clk_i  in  1  system clock (only clock)
- rst_n  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i
- cmd_we_i  in  1  1 = write burst, 0 = read burst
- cmd_addr_i  in  ADDR_WIDTH  start byte address; low log2(BYTES) bits ignored
- cmd_len_i  in  LEN_WIDTH  beats minus one
- wdata_valid_i / wdata_ready_o / wdata_i  in/out/in  1/1/DATA_WIDTH  write-beat stream
- rdata_valid_o / rdata_ready_i / rdata_o  out/in/out  1/1/DATA_WIDTH  read-beat stream (FIFO head)
- mem_req_o, mem_we_o  out  1  memory request, write enable
- mem_addr_o  out  ADDR_WIDTH  word-aligned byte address
- mem_wdata_o  out  DATA_WIDTH  equals wdata_i
- mem_be_o  out  BYTES  all ones
- mem_gnt_i, mem_rvalid_i, mem_err_i  in  1  grant, response valid, response error (valid with rvalid)
- mem_rdata_i  in  DATA_WIDTH  read data, valid with rvalid
- busy_o  out  1  state ≠ IDLE
- done_o  out  1  one-cycle pulse at burst completion
- err_o  out  1  sticky: any beat of the last burst returned mem_err_i

## Operation
- FSM states: IDLE, REQ, WAIT_RSP.
- IDLE: cmd_ready_o=1. On accept, latch we, aligned addr, len; clear beat counter and err_o; go to REQ.
- REQ:
  - Write: mem_req_o = wdata_valid_i.
  - Read: mem_req_o = !fifo_full.
  - mem_we_o = latched we.
  - wdata_ready_o = REQ & we & mem_gnt_i. A write beat is consumed exactly on grant.
  - On mem_req_o & mem_gnt_i, go to WAIT_RSP.
  - Once asserted, the request holds address and data stable until grant.
- WAIT_RSP: no request is issued; exactly one transaction is outstanding. On mem_rvalid_i:
  - Read: push mem_rdata_i into the FIFO.
  - If mem_err_i: set err_o.
  - If beat count == len: go to IDLE and pulse done_o.
  - Otherwise: beat count +1, addr += BYTES, go to REQ.
- A burst never aborts on error; all len+1 beats are performed.
- Address arithmetic is modulo 2^ADDR_WIDTH. Wrap from the top word to address 0 is silent.
- FIFO:
  - rdata_valid_o = !empty; rdata_o = head.
  - Pop on rdata_valid_o & rdata_ready_i. Push and pop in the same cycle leave occupancy unchanged.
  - Overflow is impossible: a read request requires a free slot, and the FIFO is not popped into deficit while the read is outstanding.
- The FIFO may still hold data when the FSM returns to IDLE. It drains independently, and a new command is accepted regardless of occupancy.

## Timing
- Reset values:
  - cmd_ready_o=1; mem_req_o=0, mem_we_o=0; mem_addr_o=0; wdata_ready_o=0; rdata_valid_o=0; busy_o=0, done_o=0, err_o=0.
  - FIFO empty; state IDLE.
- Reset asserted mid-burst: everything returns to reset values at once and FIFO contents are discarded. A late rvalid after reset is ignored.
- Command accepted at edge 0: mem_req_o can be high in cycle 1.
- With gnt in the request cycle and rvalid the next cycle, one beat takes 2 cycles. An N-beat burst takes 2N cycles from accept to the last rvalid.
- done_o is high in the cycle after the final rvalid. cmd_ready_o is high in the same cycle, so a new command is accepted at the earliest then.
- Read data is visible on rdata_o one cycle after its rvalid (registered FIFO write).
- Simultaneous cmd_valid_i and done_o: the command is accepted, and err_o clears on the following edge.

## Test plan
- **Write then read back.** Write burst of 4 beats (len=3) at addr 0x100 with data 0xA0..0xA3, gnt always high and rvalid one cycle later. Required: requests at 0x100, 0x104, 0x108, 0x10C; done_o pulses exactly once; err_o=0. Then read len=3 at 0x100 returns 0xA0..0xA3 in order.
- **Read backpressure.** RSP_DEPTH=4, read len=7 with rdata_ready_i=0. Required: mem_req_o stays low after the 4th beat is pushed. Raising rdata_ready_i resumes the burst; all 8 words arrive in order and none is lost.
- **Wait states.** Hold gnt low for 3 cycles on beat 2. Required: mem_addr_o and mem_wdata_o stay stable until grant, and exactly one wdata beat is consumed.
- **Error and address wrap.** Set mem_err_i on beat 1 of a 3-beat read starting at 0xFFFF_FFF8. Required: addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; all 3 beats performed; err_o=1 after done. err_o clears on the next command accept.
- **Reset mid-burst.** Assert rst_n low while in WAIT_RSP of beat 2 of 4. Required: outputs return to reset values immediately, the FIFO is empty, and a later rvalid produces no push.
- **Back-to-back commands.** Present a new command in the done_o cycle. Required: it is accepted in that cycle, and its first request appears in the next cycle.
